// File: rtl/ram_design.sv
`default_nettype none
// ============================================================================
//  Module   : ram_design
//  Purpose  : Single-port synchronous scratch RAM. One address per cycle,
//             separate write/read enables, registered read data, read-first
//             behaviour on a simultaneous read/write of the same word.
//             Synchronous active-low reset clears every word and data_out.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_design #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    // Read-side view of every word, gathered for the address mux
    logic [DATA_WIDTH-1:0] w_words [c_DEPTH];

    logic [DATA_WIDTH-1:0] data_out_q;
    logic [DATA_WIDTH-1:0] data_out_d;

    // One register per word; the write strobe is qualified by write_enb first
    // so an unknown address while idle can never select a word.
    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_word
        logic                  w_we;
        logic [DATA_WIDTH-1:0] word_q;

        assign w_we = write_enb && (address == ADDR_WIDTH'(gi));

        // Clear on reset (overrides any write), otherwise load on a selected write
        always_ff @(posedge clk) begin
            if (!reset) begin
                word_q <= '0;
            end else if (w_we) begin
                word_q <= data_in;
            end
        end

        assign w_words[gi] = word_q;
    end

    // Select the addressed word on a read; hold the previous value when idle.
    // The mux sees the pre-edge contents, which gives read-first on collision.
    always_comb begin
        data_out_d = data_out_q;
        if (read_enb) begin
            data_out_d = w_words[address];
        end
    end

    // Register the read data; reset clears it regardless of the enables
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_design.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_design
//  Purpose  : Self-checking bench for ram_design. Directed vector table,
//             hand-written reset-in-flight sequence and a random run against
//             a reference array; expected data_out values go through a queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_design;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          write_enb;
    logic          read_enb;
    logic [AW-1:0] address;
    logic [DW-1:0] data_out;

    ram_design #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .write_enb (write_enb),
        .read_enb  (read_enb),
        .address   (address),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_out;

    // Scoreboard of expected data_out values, one per driven cycle
    logic [DW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rst;
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    // Drive one cycle at the falling edge, update the model, push the
    // expectation, then compare just after the rising edge.
    task automatic step(input logic rst, input logic we, input logic re,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit use_exp, input logic [DW-1:0] exp,
                        input string name);
        logic [DW-1:0] want;
        @(negedge clk);
        reset     = rst;
        write_enb = we;
        read_enb  = re;
        address   = a;
        data_in   = d;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            model_out = '0;
        end else begin
            if (re) model_out = model_mem[a];
            if (we) model_mem[a] = d;
        end
        exp_q.push_back(use_exp ? exp : model_out);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (data_out !== want) begin
            errors++;
            $display("FAIL %s: data_out=%h expected=%h (t=%0t)", name, data_out, want, $time);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        logic          rwe, rre, rrst;

        reset     = 1'b0;
        write_enb = 1'b0;
        read_enb  = 1'b0;
        address   = '0;
        data_in   = '0;
        model_out = '0;

        //            rst   we    re    addr    din    exp
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'h00, 8'h00, 8'h00}; // reset edge
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'h00, 8'h77, 8'h00}; // enables ignored in reset
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 5'h00, 8'h00, 8'h00}; // first read after reset
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 5'h03, 8'hA5, 8'h00}; // write 0x03
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 5'h1F, 8'h3C, 8'h00}; // write top address
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 5'h03, 8'h00, 8'hA5}; // read 0x03
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 5'h1F, 8'h00, 8'h3C}; // read 0x1F
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 5'h03, 8'h00, 8'hA5}; // read 0x03 again
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 5'h1F, 8'h12, 8'hA5}; // hold, addr toggles
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 5'h00, 8'h34, 8'hA5}; // hold
        vecs[10] = '{1'b1, 1'b0, 1'b0, 5'hxx, 8'hxx, 8'hA5}; // hold, X inputs idle
        vecs[11] = '{1'b1, 1'b1, 1'b0, 5'h07, 8'h11, 8'hA5}; // write 0x07
        vecs[12] = '{1'b1, 1'b1, 1'b1, 5'h07, 8'h99, 8'h11}; // collision: read-first
        vecs[13] = '{1'b1, 1'b0, 1'b1, 5'h07, 8'h00, 8'h99}; // new data visible
        vecs[14] = '{1'b1, 1'b0, 1'b1, 5'h03, 8'h00, 8'hA5}; // X cycle left 0x03 intact
        vecs[15] = '{1'b1, 1'b0, 1'b1, 5'h1F, 8'h00, 8'h3C}; // X cycle left 0x1F intact

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].din,
                 1'b1, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Fill every word with address^0x5A, spot-check, then reset mid-write
        for (int i = 0; i < DEPTH; i++) begin
            ra = AW'(i);
            step(1'b1, 1'b1, 1'b0, ra, DW'(i) ^ 8'h5A, 1'b1,
                 (i == 0) ? 8'h3C : 8'h3C, "fill_hold");
        end
        step(1'b1, 1'b0, 1'b1, 5'h04, 8'h00, 1'b1, 8'h5E, "fill_rd04");
        step(1'b1, 1'b0, 1'b1, 5'h1F, 8'h00, 1'b1, 8'h45, "fill_rd1F");
        step(1'b0, 1'b1, 1'b0, 5'h04, 8'hFF, 1'b1, 8'h00, "rst_mid_write");
        for (int i = 0; i < DEPTH; i++) begin
            ra = AW'(i);
            step(1'b1, 1'b0, 1'b1, ra, 8'h00, 1'b1, 8'h00, $sformatf("post_rst_rd%0d", i));
        end

        // Random regression against the reference model
        for (int i = 0; i < 500; i++) begin
            rrst = ($urandom_range(0, 49) != 0);
            rwe  = 1'($urandom_range(0, 1));
            rre  = 1'($urandom_range(0, 1));
            ra   = AW'($urandom_range(0, DEPTH - 1));
            rd   = DW'($urandom);
            step(rrst, rwe, rre, ra, rd, 1'b0, 8'h00, "random");
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
